dmem_responder: RTL
===================

Name: dmem_responder

Overview:
Responder side of the core's data-memory load/store interface: a word-addressed data RAM with a registered multi-cycle response.
- Sits between the processor datapath (request initiator) and backing storage.
- Accepts one request at a time; inserts LATENCY wait cycles; returns a one-cycle ready pulse with read data or an address-error flag.
- Gives the core a stall source (busy) so the datapath can move from an ideal single-cycle memory to a multi-cycle one.

Parameters:
SIZE, 32, data and address width in bits
DEPTH, 512, number of words in the RAM
ADDR_W, 9, index bits used; must equal clog2(DEPTH)
LATENCY, 2, wait cycles between accept and response; legal range 1..15

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
mem_read  input  1  load request
mem_write  input  1  store request
address  input  SIZE  word address (not byte address)
write_data  input  SIZE  store data (rt)
read_data  output  SIZE  load data; valid only while ready=1
ready  output  1  one-cycle response pulse
busy  output  1  high from the accept edge until the response is delivered; core stalls on it
addr_err  output  1  valid with ready; request addressed outside 0..DEPTH-1

Behaviour:
- All outputs are registered. Reset drives read_data=0, ready=0, busy=0, addr_err=0 and state=IDLE. RAM contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE: request = mem_read|mem_write, sampled at the rising edge.
  - On a request, the edge (E0) accepts it. State goes to WAIT, busy=1, cnt=LATENCY-1.
  - Address, flags and the read result are captured at E0.
- Store commit: a store commits to RAM at E0 when address<DEPTH. A reset after E0 never undoes a committed store.
- Load: the word is read at E0 and held internally until RESP.
- Out of range: address>=DEPTH (any bit above ADDR_W-1 set).
  - No RAM access; the store is dropped.
  - Response carries read_data=0 and addr_err=1.
- mem_read and mem_write both high: the store commits and the load returns the pre-write contents (read-before-write). Neither is an error.
- WAIT: cnt decrements each edge. The edge with cnt==0 moves to RESP, ready=1, read_data=captured word (0 for pure stores), addr_err as captured.
- RESP: lasts exactly one cycle. The next edge returns to IDLE with ready=0, busy=0, addr_err=0; read_data holds its value.
- Timing: ready is high in the cycle after edge E0+LATENCY, so the total request-to-response time is LATENCY+1 cycles.
- Requests seen in WAIT or RESP are ignored, never queued. The initiator holds the request until ready and drops it in the ready cycle.
- A request still present in the first IDLE cycle after RESP is a new request.
- Back-to-back requests: minimum spacing between accepts is LATENCY+2 edges.
- Reset during WAIT or RESP: returns to IDLE immediately (asynchronous). No ready is issued for the aborted request.

Optional Feature:
Macro DMEM_STATS_EN.
- Defined: adds outputs rd_count[15:0], wr_count[15:0] and err_count[15:0].
  - Each is incremented at E0 for an accepted load, an accepted store, or an out-of-range request respectively.
  - A request with both flags increments both rd_count and wr_count.
  - Counters saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Store then load (LATENCY=2): store 32'hDEADBEEF to address 5, wait for ready; then load address 5 -> ready pulses one cycle, 3 cycles after accept, with read_data=32'hDEADBEEF and addr_err=0; busy high for exactly 3 cycles per request.
- Out of range: load address 600 -> ready with read_data=0 and addr_err=1. Store 32'h1 to address 512 -> addr_err=1 and no RAM word changes (verify by reading 0..511 back).
- Read-before-write: address 7 holds 32'h11; assert mem_read=mem_write=1 with write_data 32'h22 -> response read_data=32'h11; a following load of address 7 returns 32'h22.
- Reset mid-operation: accept a load of address 3, assert reset in the WAIT cycle -> busy=0, ready never pulses. A store accepted before reset remains visible in a later load.
- Held request: keep mem_read high through WAIT and RESP, then drop it in the ready cycle -> exactly one ready pulse. Keep it high one cycle past ready -> a second accept starts in the next IDLE cycle.
- With DMEM_STATS_EN defined: 3 loads, 2 stores and 1 out-of-range load -> rd_count=4, wr_count=2, err_count=1. Reset -> all counters 0.

Source files
------------

// File: rtl/dmem_responder.sv
// Word-addressed data RAM responder with a fixed LATENCY-cycle registered response.
// Define DMEM_STATS_EN to add saturating load/store/error request counters.
module dmem_responder #(
    parameter int unsigned SIZE    = 32,
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [SIZE-1:0] address,
    input  logic [SIZE-1:0] write_data,
    output logic [SIZE-1:0] read_data,
    output logic            ready,
    output logic            busy,
    output logic            addr_err
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]     rd_count,
    output logic [15:0]     wr_count,
    output logic [15:0]     err_count
`endif
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SIZE-1:0]   read_data_q, read_data_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              addr_err_q, addr_err_d;
    logic              err_q;
    logic [SIZE-1:0]   rd_word_q;
    logic [SIZE-1:0]   mem [DEPTH];

    logic              req_c, accept_c, in_range_c;
    logic [ADDR_W-1:0] idx_c;

    assign req_c      = mem_read | mem_write;
    assign accept_c   = (state_q == ST_IDLE) && req_c && !reset;
    assign in_range_c = address < SIZE'(DEPTH);
    assign idx_c      = address[ADDR_W-1:0];

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            read_data_q <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            addr_err_q  <= addr_err_d;
            if (accept_c) err_q <= !in_range_c;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) state_d = ST_RESP;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        read_data_d = read_data_q;
        ready_d     = 1'b0;
        busy_d      = busy_q;
        addr_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: busy_d = req_c;
            ST_WAIT: begin
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    ready_d     = 1'b1;
                    read_data_d = rd_word_q;
                    addr_err_d  = err_q;
                end
            end
            ST_RESP: busy_d = 1'b0;
            default: busy_d = 1'b0;
        endcase
    end

    // RAM: non-blocking read and write at the accept edge give read-before-write
    always_ff @(posedge clk) begin
        if (accept_c) begin
            rd_word_q <= (mem_read && in_range_c) ? mem[idx_c] : '0;
            if (mem_write && in_range_c) mem[idx_c] <= write_data;
        end
    end

    assign read_data = read_data_q;
    assign ready     = ready_q;
    assign busy      = busy_q;
    assign addr_err  = addr_err_q;

`ifdef DMEM_STATS_EN
    logic [15:0] rd_cnt_q, wr_cnt_q, err_cnt_q;

    // Saturating request counters, bumped at the accept edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else if (accept_c) begin
            if (mem_read && rd_cnt_q != 16'hFFFF)     rd_cnt_q  <= rd_cnt_q + 16'd1;
            if (mem_write && wr_cnt_q != 16'hFFFF)    wr_cnt_q  <= wr_cnt_q + 16'd1;
            if (!in_range_c && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;
    assign err_count = err_cnt_q;
`endif

endmodule
